// File: rtl/mc_bram_loader.sv
// mc_bram_loader: drains the memory-controller FIFOs and turns every popped
// word into a BRAM write (index, row, data). Channel c owns BRAMs c, c+N_CH, ...
// Each channel has a small FSM, a pop-side index/row counter and a 2-entry
// holding buffer. Pops are throttled so buffered plus in-flight words never exceed 2.
module mc_bram_loader #(
    parameter int N_CH   = 16,
    parameter int N_BRAM = 420,
    parameter int IDX_W  = 9,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 33
) (
    input  logic                     clk,
    input  logic                     r_reset_n,
    input  logic                     start,
    input  logic [N_CH-1:0]          mcfifo_empty,
    input  logic [N_CH*DATA_W-1:0]   mcfifo_data,
    output logic [N_CH-1:0]          fifo_pop,
    output logic [N_CH-1:0]          wr_valid,
    input  logic [N_CH-1:0]          wr_stall,
    output logic [N_CH*IDX_W-1:0]    wr_index,
    output logic [N_CH*ADDR_W-1:0]   wr_addr,
    output logic [N_CH*DATA_W-1:0]   wr_data,
    output logic                     load_done,
    output logic                     err_unimpl
);

    localparam int MAX_OWNED = (N_BRAM + N_CH - 1) / N_CH;
    localparam int CNT_W     = $clog2(MAX_OWNED * (2 ** ADDR_W) + 1);
    localparam int ENT_W     = IDX_W + ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ROW = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [N_CH-1:0] in_run;
    logic [N_CH-1:0] in_done;
    logic [N_CH-1:0] done_nonempty;
    logic            any_run;
    logic            start_ok;

    // A start is only honoured when no channel is mid-load.
    assign any_run  = |in_run;
    assign start_ok = start & ~any_run;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam int OWNED = (N_BRAM - c + N_CH - 1) / N_CH;
        localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(c);
        localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(c + N_CH * (OWNED - 1));
        localparam logic [CNT_W-1:0] TOTAL     = CNT_W'(OWNED * (2 ** ADDR_W));

        state_t             state;
        state_t             state_nxt;
        logic [IDX_W-1:0]   pop_idx;
        logic [ADDR_W-1:0]  pop_row;
        logic [CNT_W-1:0]   pops_issued;
        logic               pend;
        logic [IDX_W-1:0]   pend_idx;
        logic [ADDR_W-1:0]  pend_row;
        logic [ENT_W-1:0]   slot0;
        logic [ENT_W-1:0]   slot1;
        logic [1:0]         occ;
        logic [1:0]         occ_after;
        logic [1:0]         outstanding;
        logic [IDX_W:0]     idx_next_wide;
        logic               wrap;
        logic               accept;
        logic               final_accept;
        logic               pop;
        logic [IDX_W-1:0]   head_idx;
        logic [ADDR_W-1:0]  head_row;
        logic [DATA_W-1:0]  head_data;

        assign head_idx  = slot0[ENT_W-1 -: IDX_W];
        assign head_row  = slot0[DATA_W +: ADDR_W];
        assign head_data = slot0[DATA_W-1:0];

        assign accept       = (occ != 2'd0) & ~wr_stall[c];
        assign final_accept = accept & (head_idx == LAST_IDX) & (head_row == LAST_ROW);
        assign occ_after    = occ - {1'b0, accept};
        assign outstanding  = occ_after + {1'b0, pend};
        assign pop          = (state == RUN) & ~mcfifo_empty[c] &
                              (outstanding < 2'd2) & (pops_issued < TOTAL);

        // Index advances by N_CH; the extra bit keeps c+N_CH from overflowing.
        assign idx_next_wide = {1'b0, pop_idx} + (IDX_W + 1)'(N_CH);
        assign wrap          = idx_next_wide >= (IDX_W + 1)'(N_BRAM);

        // Channel state register.
        always_ff @(posedge clk) begin
            if (!r_reset_n) state <= IDLE;
            else            state <= state_nxt;
        end

        // Next-state logic: load on start, finish on the final accepted write.
        always_comb begin
            state_nxt = state;
            case (state)
                IDLE:    if (start_ok)     state_nxt = RUN;
                RUN:     if (final_accept) state_nxt = DONE;
                DONE:    if (start_ok)     state_nxt = RUN;
                default:                   state_nxt = IDLE;
            endcase
        end

        // Pop-side counters, in-flight tag and the 2-entry holding buffer.
        always_ff @(posedge clk) begin
            if (!r_reset_n) begin
                pop_idx     <= FIRST_IDX;
                pop_row     <= '0;
                pops_issued <= '0;
                pend        <= 1'b0;
                pend_idx    <= '0;
                pend_row    <= '0;
                slot0       <= '0;
                slot1       <= '0;
                occ         <= 2'd0;
            end else if (start_ok) begin
                pop_idx     <= FIRST_IDX;
                pop_row     <= '0;
                pops_issued <= '0;
                pend        <= 1'b0;
                occ         <= 2'd0;
            end else begin
                if (pop) begin
                    pops_issued <= pops_issued + CNT_W'(1);
                    pend_idx    <= pop_idx;
                    pend_row    <= pop_row;
                    if (wrap) begin
                        pop_idx <= FIRST_IDX;
                        pop_row <= pop_row + ADDR_W'(1);
                    end else begin
                        pop_idx <= idx_next_wide[IDX_W-1:0];
                    end
                end
                pend <= pop;
                if (accept) slot0 <= slot1;
                if (pend) begin
                    if (occ_after == 2'd0)
                        slot0 <= {pend_idx, pend_row, mcfifo_data[c*DATA_W +: DATA_W]};
                    else
                        slot1 <= {pend_idx, pend_row, mcfifo_data[c*DATA_W +: DATA_W]};
                end
                occ <= outstanding;
            end
        end

        assign fifo_pop[c]                 = pop;
        assign wr_valid[c]                 = (occ != 2'd0);
        assign wr_index[c*IDX_W +: IDX_W]  = wr_valid[c] ? head_idx  : '0;
        assign wr_addr[c*ADDR_W +: ADDR_W] = wr_valid[c] ? head_row  : '0;
        assign wr_data[c*DATA_W +: DATA_W] = wr_valid[c] ? head_data : '0;
        assign in_run[c]                   = (state == RUN);
        assign in_done[c]                  = (state == DONE);
        assign done_nonempty[c]            = (state == DONE) & ~mcfifo_empty[c];
    end

    // Registered completion flag and sticky protocol error.
    always_ff @(posedge clk) begin
        if (!r_reset_n) begin
            load_done  <= 1'b0;
            err_unimpl <= 1'b0;
        end else begin
            load_done <= start_ok ? 1'b0 : &in_done;
            if ((start & any_run) | (|done_nonempty))
                err_unimpl <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_bram_loader.sv
// tb_mc_bram_loader: directed bench for mc_bram_loader with FIFO data model
// and an in-order write scoreboard per channel.
module tb_mc_bram_loader;

    localparam int N_CH   = 16;
    localparam int IDX_W  = 9;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 33;

    logic                   clk = 1'b0;
    logic                   r_reset_n;
    logic                   start;
    logic [N_CH-1:0]        empty_base;
    logic [N_CH-1:0]        mcfifo_empty;
    logic [N_CH*DATA_W-1:0] mcfifo_data;
    logic [N_CH-1:0]        fifo_pop;
    logic [N_CH-1:0]        wr_valid;
    logic [N_CH-1:0]        wr_stall;
    logic [N_CH*IDX_W-1:0]  wr_index;
    logic [N_CH*ADDR_W-1:0] wr_addr;
    logic [N_CH*DATA_W-1:0] wr_data;
    logic                   load_done;
    logic                   err_unimpl;

    logic                   tog_en;
    logic                   tog15 = 1'b0;
    logic                   sb_clr;
    logic [N_CH-1:0]        pop_s = '0;
    int                     pop_cnt [N_CH];
    int                     wr_cnt  [N_CH];
    int                     compared   = 0;
    int                     mismatched = 0;

    always #5 clk = ~clk;

    assign mcfifo_empty = empty_base | {tog_en & tog15, {(N_CH-1){1'b0}}};

    mc_bram_loader dut (
        .clk          (clk),
        .r_reset_n    (r_reset_n),
        .start        (start),
        .mcfifo_empty (mcfifo_empty),
        .mcfifo_data  (mcfifo_data),
        .fifo_pop     (fifo_pop),
        .wr_valid     (wr_valid),
        .wr_stall     (wr_stall),
        .wr_index     (wr_index),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .load_done    (load_done),
        .err_unimpl   (err_unimpl)
    );

    function automatic int owned(int c);
        return (c < 4) ? 27 : 26;
    endfunction

    function automatic int total(int c);
        return owned(c) * 64;
    endfunction

    function automatic logic [DATA_W-1:0] pattern(int c, int k);
        if (c == 5 && k == 0) return 33'h1_2345_6789;
        return {4'(c), 5'h15, 24'(k)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel 15 FIFO flips between empty and non-empty every cycle when enabled.
    always @(posedge clk) tog15 <= ~tog15;

    // FIFO model: data for a pop seen in cycle T is presented during T+1.
    always @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (sb_clr) begin
                pop_cnt[c] <= 0;
            end else if (pop_s[c]) begin
                mcfifo_data[c*DATA_W +: DATA_W] <= pattern(c, pop_cnt[c]);
                pop_cnt[c] <= pop_cnt[c] + 1;
            end
        end
    end

    // Pop legality and in-order write scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        pop_s <= fifo_pop;
        for (int c = 0; c < N_CH; c++) begin
            if (sb_clr) begin
                wr_cnt[c] <= 0;
            end else begin
                if (fifo_pop[c]) begin
                    check("pop_nonempty", 64'(mcfifo_empty[c]), 64'd0);
                    check("pop_limit", 64'(pop_cnt[c] < total(c)), 64'd1);
                end
                if (wr_valid[c] && !wr_stall[c]) begin
                    check("wr_index", 64'(wr_index[c*IDX_W +: IDX_W]),
                          64'(c + 16 * (wr_cnt[c] % owned(c))));
                    check("wr_addr", 64'(wr_addr[c*ADDR_W +: ADDR_W]),
                          64'(wr_cnt[c] / owned(c)));
                    check("wr_data", 64'(wr_data[c*DATA_W +: DATA_W]),
                          64'(pattern(c, wr_cnt[c])));
                    wr_cnt[c] <= wr_cnt[c] + 1;
                end
            end
        end
    end

    initial begin
        int                p0;
        int                sum;
        logic [IDX_W-1:0]  s_idx;
        logic [ADDR_W-1:0] s_addr;
        logic [DATA_W-1:0] s_data;

        r_reset_n   = 1'b0;
        start       = 1'b0;
        empty_base  = '0;
        wr_stall    = '0;
        tog_en      = 1'b0;
        sb_clr      = 1'b1;
        mcfifo_data = '0;
        tick();
        tick();
        sb_clr = 1'b0;

        check("rst_fifo_pop", 64'(fifo_pop), 64'd0);
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_err", 64'(err_unimpl), 64'd0);
        check("rst_wr_index", 64'(wr_index[IDX_W-1:0]), 64'd0);
        check("rst_wr_data", 64'(wr_data[DATA_W-1:0]), 64'd0);

        r_reset_n = 1'b1;
        tog_en    = 1'b1;
        tick();

        start  = 1'b1;
        sb_clr = 1'b1;
        tick();
        start  = 1'b0;
        sb_clr = 1'b0;
        check("first_pop_ch5", 64'(fifo_pop[5]), 64'd1);
        check("load_done_run", 64'(load_done), 64'd0);
        tick();
        check("ch5_valid_t1", 64'(wr_valid[5]), 64'd0);
        tick();
        check("ch5_valid_t2", 64'(wr_valid[5]), 64'd1);
        check("ch5_data", 64'(wr_data[5*DATA_W +: DATA_W]), 64'h1_2345_6789);
        check("ch5_index", 64'(wr_index[5*IDX_W +: IDX_W]), 64'd5);
        check("ch5_addr", 64'(wr_addr[5*ADDR_W +: ADDR_W]), 64'd0);
        check("err_clean", 64'(err_unimpl), 64'd0);

        repeat (40) tick();
        wr_stall[3] = 1'b1;
        p0     = pop_cnt[3];
        s_idx  = wr_index[3*IDX_W +: IDX_W];
        s_addr = wr_addr[3*ADDR_W +: ADDR_W];
        s_data = wr_data[3*DATA_W +: DATA_W];
        check("stall_valid", 64'(wr_valid[3]), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_idx", 64'(wr_index[3*IDX_W +: IDX_W]), 64'(s_idx));
            check("stall_addr", 64'(wr_addr[3*ADDR_W +: ADDR_W]), 64'(s_addr));
            check("stall_data", 64'(wr_data[3*DATA_W +: DATA_W]), 64'(s_data));
        end
        check("stall_pops", 64'((pop_cnt[3] - p0) <= 2), 64'd1);
        wr_stall[3] = 1'b0;

        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_start_run", 64'(err_unimpl), 64'd1);
        repeat (5) tick();
        check("err_held", 64'(err_unimpl), 64'd1);
        check("load_continues", 64'(load_done), 64'd0);

        for (int i = 0; i < 6000 && load_done !== 1'b1; i++) tick();
        check("load_done_first", 64'(load_done), 64'd1);
        check("err_sticky", 64'(err_unimpl), 64'd1);
        sum = 0;
        for (int c = 0; c < N_CH; c++) begin
            check("wr_count", 64'(wr_cnt[c]), 64'(total(c)));
            sum += wr_cnt[c];
        end
        check("wr_total", 64'(sum), 64'd26880);
        tog_en = 1'b0;

        start  = 1'b1;
        sb_clr = 1'b1;
        tick();
        start  = 1'b0;
        sb_clr = 1'b0;
        check("restart_done_drop", 64'(load_done), 64'd0);
        check("restart_pops", 64'(fifo_pop), 64'hFFFF);
        tick();
        tick();
        check("restart_valid", 64'(wr_valid), 64'hFFFF);
        check("restart_idx0", 64'(wr_index[IDX_W-1:0]), 64'd0);
        check("restart_addr0", 64'(wr_addr[ADDR_W-1:0]), 64'd0);

        repeat (30) tick();
        r_reset_n = 1'b0;
        sb_clr    = 1'b1;
        tick();
        r_reset_n = 1'b1;
        sb_clr    = 1'b0;
        check("midrst_pop", 64'(fifo_pop), 64'd0);
        check("midrst_valid", 64'(wr_valid), 64'd0);
        check("midrst_index", 64'(wr_index[63:0]), 64'd0);
        check("midrst_addr", 64'(wr_addr[63:0]), 64'd0);
        check("midrst_data", 64'(wr_data[63:0]), 64'd0);
        check("midrst_done", 64'(load_done), 64'd0);
        check("midrst_err", 64'(err_unimpl), 64'd0);
        repeat (3) tick();
        check("midrst_no_pop", 64'(fifo_pop), 64'd0);

        start  = 1'b1;
        sb_clr = 1'b1;
        tick();
        start  = 1'b0;
        sb_clr = 1'b0;
        repeat (1730) tick();
        check("load_done_early", 64'(load_done), 64'd0);
        tick();
        check("load_done_timing", 64'(load_done), 64'd1);
        check("final_count_ch0", 64'(wr_cnt[0]), 64'd1728);
        check("final_count_ch15", 64'(wr_cnt[15]), 64'd1664);
        check("err_done_nonempty", 64'(err_unimpl), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
